// File: rtl/v_pkg.sv
// Shared payload types for the level-0 change notification path.
package v_pkg;

  typedef logic [7:0]  id_t;
  typedef logic [15:0] key_t;
  typedef logic [11:0] size_t;

  typedef struct packed {
    logic  valid;
    id_t   prod_id;
    key_t  key;
    size_t size;
  } ntf_entry_t;

endpackage

// File: rtl/v_notify_q_match.sv
// Parallel prod_id comparator across all queue entries; one-hot hit because ids are unique.
module v_notify_q_match
  import v_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic [DEPTH-1:0] valid_i,
  input  id_t  [DEPTH-1:0] ids_i,
  input  id_t              prod_id_i,
  output logic [DEPTH-1:0] hit_o
);

  always_comb begin
    hit_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit_o[i] = valid_i[i] && (ids_i[i] == prod_id_i);
    end
  end

endmodule

// File: rtl/v_notify_q.sv
// Coalescing notification queue: one live entry per prod_id, in-order delivery over
// valid/ready, saturating count of events dropped while full.
module v_notify_q
  import v_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_lv0_vld,
  input  id_t                    i_lv0_prod_id,
  input  key_t                   i_lv0_key,
  input  size_t                  i_lv0_size,
  input  logic                   i_flush,
  output logic                   o_ntf_vld,
  input  logic                   i_ntf_rdy,
  output id_t                    o_ntf_prod_id,
  output key_t                   o_ntf_key,
  output size_t                  o_ntf_size,
  output logic [$clog2(DEPTH):0] o_level_r,
  output logic [CNT_W-1:0]       o_ovf_cnt_r
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  ntf_entry_t       mem_q [DEPTH];
  ntf_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;

  logic [DEPTH-1:0] ent_valid;
  id_t  [DEPTH-1:0] ent_ids;
  logic [DEPTH-1:0] hit;
  logic [PTR_W-1:0] hit_idx;
  logic             hit_any;
  logic             hit_head;
  logic             full;
  logic             pop;
  logic             coalesce;
  logic             push;
  logic             drop;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_valid[i] = mem_q[i].valid;
      ent_ids[i]   = mem_q[i].prod_id;
    end
  end

  v_notify_q_match #(
    .DEPTH(DEPTH)
  ) u_match (
    .valid_i  (ent_valid),
    .ids_i    (ent_ids),
    .prod_id_i(i_lv0_prod_id),
    .hit_o    (hit)
  );

  always_comb begin
    hit_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (hit[i]) hit_idx = PTR_W'(i);
    end
  end

  assign hit_any  = |hit;
  assign hit_head = hit_any && (hit_idx == head_q);
  assign full     = (level_q == LVL_W'(DEPTH));
  assign o_ntf_vld = (level_q != '0);
  assign pop      = o_ntf_vld && i_ntf_rdy;
  // A match on the head that leaves this cycle cannot absorb the update; re-enqueue instead.
  assign coalesce = i_lv0_vld && hit_any && !(pop && hit_head);
  assign push     = i_lv0_vld && !coalesce && (!full || pop);
  assign drop     = i_lv0_vld && !coalesce && full && !pop && !i_flush;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    ovf_d   = ovf_q;

    if (drop && (ovf_q != '1)) ovf_d = ovf_q + 1'b1;

    if (i_flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
    end else begin
      if (pop) begin
        mem_d[head_q].valid = 1'b0;
        head_d = head_q + 1'b1;
      end
      if (coalesce) begin
        mem_d[hit_idx].key  = i_lv0_key;
        mem_d[hit_idx].size = i_lv0_size;
      end
      // Full with pop: tail equals head, so the write lands after the pop clear.
      if (push) begin
        mem_d[tail_q] = '{valid: 1'b1, prod_id: i_lv0_prod_id, key: i_lv0_key,
                          size: i_lv0_size};
        tail_d = tail_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      ovf_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_ntf_prod_id = mem_q[head_q].prod_id;
  assign o_ntf_key     = mem_q[head_q].key;
  assign o_ntf_size    = mem_q[head_q].size;
  assign o_level_r     = level_q;
  assign o_ovf_cnt_r   = ovf_q;

endmodule

// File: tb/tb_v_notify_q.sv
// Directed bench for v_notify_q: queue-based reference model checked every cycle,
// plus literal expectations for the named scenarios.
module tb_v_notify_q;
  import v_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 16;

  logic                   clk;
  logic                   rst_n;
  logic                   i_lv0_vld;
  id_t                    i_lv0_prod_id;
  key_t                   i_lv0_key;
  size_t                  i_lv0_size;
  logic                   i_flush;
  logic                   o_ntf_vld;
  logic                   i_ntf_rdy;
  id_t                    o_ntf_prod_id;
  key_t                   o_ntf_key;
  size_t                  o_ntf_size;
  logic [$clog2(DEPTH):0] o_level_r;
  logic [CNT_W-1:0]       o_ovf_cnt_r;

  int checks   = 0;
  int failures = 0;

  v_notify_q #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_lv0_vld    (i_lv0_vld),
    .i_lv0_prod_id(i_lv0_prod_id),
    .i_lv0_key    (i_lv0_key),
    .i_lv0_size   (i_lv0_size),
    .i_flush      (i_flush),
    .o_ntf_vld    (o_ntf_vld),
    .i_ntf_rdy    (i_ntf_rdy),
    .o_ntf_prod_id(o_ntf_prod_id),
    .o_ntf_key    (o_ntf_key),
    .o_ntf_size   (o_ntf_size),
    .o_level_r    (o_level_r),
    .o_ovf_cnt_r  (o_ovf_cnt_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of pending notifications keyed by id.
  typedef struct {
    bit [7:0]  id;
    bit [15:0] key;
    bit [11:0] size;
  } m_ent_t;

  m_ent_t mq[$];
  int     m_ovf = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_ovf = 0;
      end else if (i_flush) begin
        mq.delete();
      end else begin
        int     found;
        m_ent_t e;
        if (mq.size() != 0 && i_ntf_rdy) void'(mq.pop_front());
        if (i_lv0_vld) begin
          found = -1;
          foreach (mq[j]) if (mq[j].id == i_lv0_prod_id) found = j;
          if (found >= 0) begin
            mq[found].key  = i_lv0_key;
            mq[found].size = i_lv0_size;
          end else if (mq.size() < DEPTH) begin
            e.id = i_lv0_prod_id;
            e.key = i_lv0_key;
            e.size = i_lv0_size;
            mq.push_back(e);
          end else if (m_ovf < (1 << CNT_W) - 1) begin
            m_ovf++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_vld", 32'(o_ntf_vld), 32'(mq.size() != 0));
      check("cyc_level", 32'(o_level_r), 32'(mq.size()));
      check("cyc_ovf", 32'(o_ovf_cnt_r), 32'(m_ovf));
      if (mq.size() != 0) begin
        check("cyc_id", 32'(o_ntf_prod_id), 32'(mq[0].id));
        check("cyc_key", 32'(o_ntf_key), 32'(mq[0].key));
        check("cyc_size", 32'(o_ntf_size), 32'(mq[0].size));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input bit [7:0] id, input bit [15:0] key, input bit [11:0] sz);
    i_lv0_vld     = 1'b1;
    i_lv0_prod_id = id;
    i_lv0_key     = key;
    i_lv0_size    = sz;
    step();
    i_lv0_vld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_lv0_vld = 1'b0;
    i_lv0_prod_id = '0;
    i_lv0_key = '0;
    i_lv0_size = '0;
    i_flush = 1'b0;
    i_ntf_rdy = 1'b0;
    step();
    step();
    check("rst_vld", 32'(o_ntf_vld), 32'd0);
    check("rst_level", 32'(o_level_r), 32'd0);
    check("rst_ovf", 32'(o_ovf_cnt_r), 32'd0);
    rst_n = 1'b1;
    step();

    // Single event latency
    i_ntf_rdy = 1'b1;
    ev(8'd3, 16'h0010, 12'd5);
    check("lat_vld1", 32'(o_ntf_vld), 32'd1);
    check("lat_id", 32'(o_ntf_prod_id), 32'd3);
    check("lat_key", 32'(o_ntf_key), 32'h10);
    check("lat_size", 32'(o_ntf_size), 32'd5);
    step();
    check("lat_vld2", 32'(o_ntf_vld), 32'd0);

    // Coalesce in place
    i_ntf_rdy = 1'b0;
    ev(8'd1, 16'h000A, 12'd1);
    ev(8'd2, 16'h000B, 12'd2);
    ev(8'd1, 16'h000C, 12'd3);
    check("coal_level", 32'(o_level_r), 32'd2);
    check("coal_id0", 32'(o_ntf_prod_id), 32'd1);
    check("coal_key0", 32'(o_ntf_key), 32'hC);
    i_ntf_rdy = 1'b1;
    step();
    check("coal_id1", 32'(o_ntf_prod_id), 32'd2);
    check("coal_key1", 32'(o_ntf_key), 32'hB);
    step();
    check("coal_empty", 32'(o_ntf_vld), 32'd0);

    // Overflow: ten distinct ids into eight entries
    i_ntf_rdy = 1'b0;
    for (int i = 0; i < 10; i++) ev(8'(i), 16'(16'h100 + i), 12'(i));
    check("ovf_level", 32'(o_level_r), 32'd8);
    check("ovf_cnt", 32'(o_ovf_cnt_r), 32'd2);
    i_ntf_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ovf_order", 32'(o_ntf_prod_id), 32'(i));
      step();
    end
    check("ovf_drained", 32'(o_ntf_vld), 32'd0);

    // Match on the head while it pops: re-enqueued at tail
    i_ntf_rdy = 1'b0;
    ev(8'd4, 16'h0011, 12'd1);
    ev(8'd5, 16'h0055, 12'd2);
    i_ntf_rdy = 1'b1;
    ev(8'd4, 16'h0022, 12'd3);
    i_ntf_rdy = 1'b0;
    check("hp_level", 32'(o_level_r), 32'd2);
    check("hp_head", 32'(o_ntf_prod_id), 32'd5);
    i_ntf_rdy = 1'b1;
    step();
    check("hp_tail_id", 32'(o_ntf_prod_id), 32'd4);
    check("hp_tail_key", 32'(o_ntf_key), 32'h22);
    step();
    check("hp_empty", 32'(o_ntf_vld), 32'd0);

    // Full with simultaneous pop, then flush with a competing event
    i_ntf_rdy = 1'b0;
    for (int i = 10; i < 18; i++) ev(8'(i), 16'(i), 12'(i));
    check("fp_full", 32'(o_level_r), 32'd8);
    i_ntf_rdy = 1'b1;
    ev(8'd20, 16'h0020, 12'd20);
    i_ntf_rdy = 1'b0;
    check("fp_level", 32'(o_level_r), 32'd8);
    check("fp_ovf", 32'(o_ovf_cnt_r), 32'd2);
    check("fp_head", 32'(o_ntf_prod_id), 32'd11);
    i_flush = 1'b1;
    ev(8'd21, 16'h0021, 12'd21);
    i_flush = 1'b0;
    check("fl_level", 32'(o_level_r), 32'd0);
    check("fl_vld", 32'(o_ntf_vld), 32'd0);
    check("fl_ovf", 32'(o_ovf_cnt_r), 32'd2);

    // Asynchronous reset with entries queued
    for (int i = 30; i < 35; i++) ev(8'(i), 16'(i), 12'(i));
    check("ar_level_pre", 32'(o_level_r), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_vld", 32'(o_ntf_vld), 32'd0);
    check("ar_level", 32'(o_level_r), 32'd0);
    check("ar_ovf", 32'(o_ovf_cnt_r), 32'd0);
    step();
    rst_n = 1'b1;
    i_ntf_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ar_quiet", 32'(o_ntf_vld), 32'd0);
    end
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/v_notify_q.md
V_NOTIFY_Q -- requirements
Module: v_notify_q

Interface
REQ-001 Parameter DEPTH, default 8, meaning notification queue entries; power of two, 2..32.
REQ-002 Parameter CNT_W, default 16, meaning overflow counter width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_lv0_vld  input  1  level-0 change notification valid, one cycle per event.
REQ-006 i_lv0_prod_id  input  v_pkg::id_t  product of the event.
REQ-007 i_lv0_key  input  v_pkg::key_t  new level-0 key.
REQ-008 i_lv0_size  input  v_pkg::size_t  new level-0 size.
REQ-009 i_flush  input  1  synchronous discard of all queued entries.
REQ-010 o_ntf_vld  output  1  head entry available.
REQ-011 i_ntf_rdy  input  1  consumer accepts head when o_ntf_vld is high.
REQ-012 o_ntf_prod_id / o_ntf_key / o_ntf_size  output  v_pkg types  head entry fields.
REQ-013 o_level_r  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 o_ovf_cnt_r  output  CNT_W  saturating count of dropped events.

Function
REQ-015 The block SHALL queue each level-0 notification and deliver it in arrival order over a valid/ready handshake; pop occurs when o_ntf_vld and i_ntf_rdy are both high.
REQ-016 Output fields SHALL be driven directly from head-entry registers; an event arriving at cycle N into an empty queue SHALL show o_ntf_vld high at cycle N+1.
REQ-017 Coalescing: if a valid entry with equal prod_id is already queued and is not being popped this cycle, the block SHALL overwrite that entry's key/size in place, leave its position unchanged, and not change occupancy.
REQ-018 If the matching entry is the head and is popped in the same cycle, the event SHALL instead be enqueued as a new tail entry.
REQ-019 At most one queued entry per prod_id SHALL exist at any time.
REQ-020 When no match exists and the queue is not full, the event SHALL be written at the tail, occupancy +1.
REQ-021 When full, no match exists and no pop occurs, the event SHALL be dropped and o_ovf_cnt_r incremented, saturating at all-ones.
REQ-022 When full with a simultaneous pop, the event SHALL be accepted (occupancy unchanged) and not counted as overflow.
REQ-023 o_ntf_vld SHALL not depend combinationally on i_ntf_rdy; o_ntf_* SHALL hold stable while o_ntf_vld is high and i_ntf_rdy low, except key/size updates by coalescing per REQ-017.
REQ-024 Pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH nor underflow.
REQ-025 i_flush SHALL empty the queue next cycle and takes priority over push, pop and coalesce in the same cycle; o_ovf_cnt_r is unaffected by flush.

Reset
REQ-026 On rst_n low: o_ntf_vld=0, o_level_r=0, o_ovf_cnt_r=0, head/tail pointers 0, all entry valid bits 0; entry payload need not be reset.
REQ-027 Reset asserted mid-transfer SHALL discard all entries; no event is delivered after rst_n deasserts unless newly received.

Structure
REQ-028 Entry struct (valid, prod_id, key, size) SHALL be a typedef in v_pkg; id_t/key_t/size_t reused from v_pkg.
REQ-029 Payload storage SHALL be flop-based, DEPTH entries, to permit parallel prod_id match.
REQ-030 One sub-module, v_notify_q_match (DEPTH-wide prod_id comparator producing a one-hot hit vector), is natural; everything else is inline.

Verification
REQ-031 Empty queue, event id=3 key=0x10 size=5 at cycle 0, rdy=1 -> o_ntf_vld high cycle 1 with id=3 key=0x10 size=5, low cycle 2.
REQ-032 rdy=0; events id=1 key=A, id=2 key=B, id=1 key=C -> o_level_r=2; drain yields id=1 key=C then id=2 key=B.
REQ-033 rdy=0, DEPTH=8, ten events with distinct ids -> o_level_r=8, o_ovf_cnt_r=2; ids 0..7 delivered in order.
REQ-034 Queue head id=4, rdy=1 and new event id=4 key=0x22 same cycle -> old head popped, new id=4 entry at tail, o_level_r unchanged.
REQ-035 Full queue, rdy=1 plus new distinct event same cycle -> accepted, o_level_r stays 8, o_ovf_cnt_r unchanged; then i_flush with event -> o_level_r=0.
REQ-036 rst_n pulsed low with 5 entries queued -> o_ntf_vld=0, o_level_r=0, o_ovf_cnt_r=0 immediately, nothing delivered after release.
